// File: rtl/bnn_input_loader_if.sv
// Host word stream into the BNN input loader.
// The master drives words and the slave returns s_ready.
interface bnn_input_loader_if #(
    parameter int DATA_W = 16
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_hdr;
    logic              s_eol;

    modport master (output s_valid, s_data, s_hdr, s_eol, input s_ready);
    modport slave  (input s_valid, s_data, s_hdr, s_eol, output s_ready);
endinterface

// File: rtl/bnn_input_loader.sv
// Packs a host header/row word stream into the engine's input SRAM image list.
// After the terminator is written, the loader launches the engine and waits for busy to drop.
module bnn_input_loader #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 16,
    parameter int MAX_ADDR = 4095
) (
    input  logic              clk,
    input  logic              reset_b,
    bnn_input_loader_if.slave s,
    output logic [ADDR_W-1:0] sram_write_address,
    output logic [DATA_W-1:0] sram_write_data,
    output logic              sram_write_enable,
    output logic              acc_run,
    input  logic              acc_busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_ROWS = 3'd2,
        ST_RUN  = 3'd3,
        ST_WAIT = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    localparam logic [1:0]        ERR_NONE = 2'd0;
    localparam logic [1:0]        ERR_DIM  = 2'd1;
    localparam logic [1:0]        ERR_OVF  = 2'd2;
    localparam logic [1:0]        ERR_PROT = 2'd3;
    localparam logic [DATA_W-1:0] TERM     = 16'h00FF;
    // Counter carries one extra bit so an address one past MAX_ADDR is detectable.
    localparam logic [ADDR_W:0]   MAX_A    = (ADDR_W+1)'(MAX_ADDR);
    localparam logic [ADDR_W:0]   ONE_A    = (ADDR_W+1)'(1);

    state_t              state_q, state_d;
    logic [ADDR_W:0]     addr_q, addr_d;
    logic [4:0]          row_q, row_d;
    logic [4:0]          dim_q, dim_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   wa_q, wa_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                run_q, run_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          code_q, code_d;
    logic                busy_q;
    logic                ready_q, ready_d;

    logic                xfer_s, hdr_s, eol_s, legal_s, room_s, last_row_s;
    logic [4:0]          dim_in_s;

    function automatic logic dim_legal(input logic [4:0] dim);
        return (dim == 5'd10) || (dim == 5'd12) || (dim == 5'd16);
    endfunction

    function automatic logic [DATA_W-1:0] row_mask(input logic [4:0] dim);
        logic [DATA_W:0] m;
        m = ((DATA_W+1)'(1) << dim) - (DATA_W+1)'(1);
        return m[DATA_W-1:0];
    endfunction

    assign xfer_s     = s.s_valid & ready_q;
    assign eol_s      = s.s_eol;
    assign hdr_s      = s.s_hdr & ~s.s_eol;
    assign dim_in_s   = s.s_data[4:0];
    assign legal_s    = dim_legal(dim_in_s);
    assign room_s     = (addr_q <= MAX_A);
    assign last_row_s = (row_q == (dim_q - 5'd1));

    // Next-state, SRAM write and handshake decode.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        row_d   = row_q;
        dim_d   = dim_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        run_d   = run_q;
        done_d  = 1'b0;
        err_d   = err_q;
        code_d  = code_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s && hdr_s) begin
                    err_d  = 1'b0;
                    code_d = ERR_NONE;
                    addr_d = '0;
                    row_d  = 5'd0;
                    dim_d  = dim_in_s;
                    if (legal_s) begin
                        we_d    = 1'b1;
                        wa_d    = '0;
                        wd_d    = s.s_data;
                        addr_d  = ONE_A;
                        state_d = ST_ROWS;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_DIM;
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (!xfer_s) begin
                    state_d = ST_HDR;
                end else if (eol_s) begin
                    if (room_s) begin
                        we_d    = 1'b1;
                        wa_d    = addr_q[ADDR_W-1:0];
                        wd_d    = TERM;
                        addr_d  = addr_q + ONE_A;
                        state_d = ST_RUN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_OVF;
                        state_d = ST_ERR;
                    end
                end else if (hdr_s) begin
                    if (!legal_s) begin
                        err_d   = 1'b1;
                        code_d  = ERR_DIM;
                        state_d = ST_ERR;
                    end else if (room_s) begin
                        we_d    = 1'b1;
                        wa_d    = addr_q[ADDR_W-1:0];
                        wd_d    = s.s_data;
                        addr_d  = addr_q + ONE_A;
                        dim_d   = dim_in_s;
                        row_d   = 5'd0;
                        state_d = ST_ROWS;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_OVF;
                        state_d = ST_ERR;
                    end
                end else begin
                    err_d   = 1'b1;
                    code_d  = ERR_PROT;
                    state_d = ST_ERR;
                end
            end
            ST_ROWS: begin
                if (!xfer_s) begin
                    state_d = ST_ROWS;
                end else if (eol_s || s.s_hdr) begin
                    err_d   = 1'b1;
                    code_d  = ERR_PROT;
                    state_d = ST_ERR;
                end else if (room_s) begin
                    we_d   = 1'b1;
                    wa_d   = addr_q[ADDR_W-1:0];
                    wd_d   = s.s_data & row_mask(dim_q);
                    addr_d = addr_q + ONE_A;
                    if (last_row_s) begin
                        row_d   = 5'd0;
                        state_d = ST_HDR;
                    end else begin
                        row_d   = row_q + 5'd1;
                    end
                end else begin
                    err_d   = 1'b1;
                    code_d  = ERR_OVF;
                    state_d = ST_ERR;
                end
            end
            ST_RUN: begin
                // Request is raised one cycle after the terminator write and held until busy is seen.
                if (run_q && acc_busy) begin
                    run_d   = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    run_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (busy_q && !acc_busy) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR: begin
                if (xfer_s && eol_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_RUN) && (state_d != ST_WAIT);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            row_q   <= 5'd0;
            dim_q   <= 5'd0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            row_q   <= row_d;
            dim_q   <= dim_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            run_q   <= run_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
            busy_q  <= acc_busy;
            ready_q <= ready_d;
        end
    end

    assign s.s_ready          = ready_q;
    assign sram_write_enable  = we_q;
    assign sram_write_address = wa_q;
    assign sram_write_data    = wd_q;
    assign acc_run            = run_q;
    assign done               = done_q;
    assign error              = err_q;
    assign err_code           = code_q;
endmodule

// File: tb/tb_bnn_input_loader.sv
// Randomized scoreboard bench for bnn_input_loader: a list-level model predicts SRAM writes,
// error codes and launches; a negedge monitor pops and compares every SRAM write.
module tb_bnn_input_loader;
    localparam int MAXA = 100;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        acc_busy = 1'b0;
    logic [11:0] sram_write_address;
    logic [15:0] sram_write_data;
    logic        sram_write_enable, acc_run, done, error;
    logic [1:0]  err_code;

    bnn_input_loader_if #(.DATA_W(16)) bus();

    bnn_input_loader #(.ADDR_W(12), .DATA_W(16), .MAX_ADDR(MAXA)) dut (
        .clk(clk), .reset_b(reset_b), .s(bus),
        .sram_write_address(sram_write_address), .sram_write_data(sram_write_data),
        .sram_write_enable(sram_write_enable), .acc_run(acc_run), .acc_busy(acc_busy),
        .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct { int a; int d; } wr_t;
    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_bad = 0;

    // List-level reference: where the host is in the list, where the next word lands.
    bit  m_loading, m_failed, m_launch, m_wrote, m_err;
    int  m_rows_left, m_dim, m_addr, m_code;
    bit  auto_launch = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit legal(input int d);
        return (d == 10) || (d == 12) || (d == 16);
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_loading = 0; m_failed = 0; m_launch = 0; m_wrote = 0; m_err = 0;
        m_rows_left = 0; m_dim = 0; m_addr = 0; m_code = 0;
    endtask

    task automatic model_fail(input int c);
        m_err = 1; m_code = c; m_failed = 1; m_loading = 0; m_rows_left = 0;
    endtask

    task automatic model_write(input int d);
        if (m_addr > MAXA) model_fail(2);
        else begin
            exp_q.push_back('{m_addr, d});
            m_wrote = 1;
            m_addr++;
        end
    endtask

    task automatic model_word(input int data, input bit hdr, input bit eol);
        int dim;
        dim = data % 32;
        m_wrote = 0;
        if (m_failed) begin
            if (eol) m_failed = 0;
        end else if (!m_loading) begin
            if (hdr && !eol) begin
                m_err = 0; m_code = 0; m_addr = 0;
                if (legal(dim)) begin
                    model_write(data);
                    m_loading = 1; m_dim = dim; m_rows_left = dim;
                end else model_fail(1);
            end
        end else if (m_rows_left > 0) begin
            if (hdr || eol) model_fail(3);
            else begin
                model_write(data % (1 << m_dim));
                if (!m_failed) m_rows_left--;
            end
        end else if (eol) begin
            model_write(16'h00FF);
            if (!m_failed) begin m_loading = 0; m_launch = 1; end
        end else if (hdr) begin
            if (!legal(dim)) model_fail(1);
            else begin
                model_write(data);
                if (!m_failed) begin m_dim = dim; m_rows_left = dim; end
            end
        end else model_fail(3);
    endtask

    // Scoreboard monitor: every SRAM write must match the head of the expected queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset_b && sram_write_enable) begin
                if (exp_q.size() == 0) chk("unexpected_write", int'(sram_write_address), -1);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", int'(sram_write_address), e.a);
                    chk("wr_data", int'(sram_write_data), e.d);
                end
            end
        end
    end

    task automatic launch();
        int cnt;
        chk("run_at_term", int'(acc_run), 0);
        @(negedge clk);
        chk("run_rise", int'(acc_run), 1);
        chk("ready_in_run", int'(bus.s_ready), 0);
        repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("run_hold", int'(acc_run), 1);
        end
        acc_busy = 1'b1;
        @(negedge clk);
        chk("run_fall", int'(acc_run), 0);
        repeat ($urandom_range(1, 3)) begin
            @(negedge clk);
            chk("ready_in_wait", int'(bus.s_ready), 0);
            chk("done_early", int'(done), 0);
        end
        acc_busy = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) chk("done_pulse", int'(done), 1);
            cnt += int'(done);
        end
        chk("done_count", cnt, 1);
        chk("ready_after", int'(bus.s_ready), 1);
    endtask

    task automatic send(input int data, input bit hdr, input bit eol, input int maxgap);
        bit got;
        bus.s_valid = 1'b0;
        repeat ($urandom_range(0, maxgap)) @(negedge clk);
        got = 0;
        bus.s_valid = 1'b1; bus.s_data = 16'(data); bus.s_hdr = hdr; bus.s_eol = eol;
        for (int i = 0; i < 40 && !got; i++) begin
            if (bus.s_ready) begin
                @(posedge clk);
                model_word(data, hdr, eol);
                got = 1;
            end
            @(negedge clk);
        end
        if (!got) chk("accept_timeout", 0, 1);
        bus.s_valid = 1'b0; bus.s_hdr = 1'b0; bus.s_eol = 1'b0;
        chk("wen", int'(sram_write_enable), int'(m_wrote));
        chk("error", int'(error), int'(m_err));
        chk("err_code", int'(err_code), m_code);
        if (m_launch) begin
            m_launch = 0;
            if (auto_launch) launch();
        end
    endtask

    task automatic load_image(input int dim, input int nrows, input int rowval, input int maxgap);
        send(dim, 1'b1, 1'b0, maxgap);
        for (int r = 0; r < nrows; r++)
            send((rowval < 0) ? int'($urandom_range(0, 65535)) : rowval, 1'b0, 1'b0, maxgap);
    endtask

    task automatic no_launch();
        repeat (4) begin
            @(negedge clk);
            chk("no_run", int'(acc_run), 0);
        end
    endtask

    task automatic chk_reset_outs();
        chk("rst_ctrl", int'({bus.s_ready, sram_write_enable, acc_run, done, error, err_code}), 0);
        chk("rst_bus", int'({sram_write_address, sram_write_data}), 0);
    endtask

    task automatic pulse_reset();
        #2 reset_b = 1'b0;
        #1 chk_reset_outs();
        model_reset();
        acc_busy = 1'b0;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int r, dim, d;
        bus.s_valid = 1'b0; bus.s_data = 16'h0; bus.s_hdr = 1'b0; bus.s_eol = 1'b0;
        model_reset();
        #3 chk_reset_outs();
        @(negedge clk);
        reset_b = 1'b1;

        // Single 10-row image, rows masked to 10 bits, then launch.
        load_image(10, 10, 16'hFFFF, 0);
        send(0, 1'b0, 1'b1, 0);

        // Two images with valid gaps.
        load_image(16, 16, -1, 1);
        load_image(12, 12, 16'hFFFF, 1);
        send(0, 1'b0, 1'b1, 1);

        // Illegal dimension, drain, then a legal header clears the error.
        send(11, 1'b1, 1'b0, 0);
        send(16'h1234, 1'b0, 1'b0, 0);
        send(0, 1'b0, 1'b1, 0);
        no_launch();
        load_image(12, 12, -1, 0);
        send(0, 1'b0, 1'b1, 0);

        // Header in the middle of an image; following rows are dropped.
        load_image(16, 5, -1, 0);
        send(10, 1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) send(16'hFFFF, 1'b0, 1'b0, 0);
        send(0, 1'b1, 1'b1, 0);
        no_launch();

        // Address overflow past MAX_ADDR suppresses the write.
        for (int i = 0; i < 6; i++) load_image(16, 16, -1, 0);
        send(0, 1'b0, 1'b1, 0);
        no_launch();

        // Reset during ROWS, during RUN and during WAIT.
        load_image(16, 5, -1, 0);
        pulse_reset();
        auto_launch = 1'b0;
        load_image(10, 10, -1, 0);
        send(0, 1'b0, 1'b1, 0);
        @(negedge clk);
        chk("run_before_rst", int'(acc_run), 1);
        pulse_reset();
        load_image(12, 12, -1, 0);
        send(0, 1'b0, 1'b1, 0);
        @(negedge clk);
        acc_busy = 1'b1;
        @(negedge clk);
        pulse_reset();
        auto_launch = 1'b1;
        load_image(10, 10, -1, 0);
        send(0, 1'b0, 1'b1, 0);

        // Random word stream biased toward well-formed lists.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            case ($urandom_range(0, 4))
                0: dim = 11;
                1: dim = $urandom_range(0, 31);
                2: dim = 10;
                3: dim = 12;
                default: dim = 16;
            endcase
            d = int'($urandom_range(0, 2047)) * 32 + dim;
            if (m_loading && m_rows_left == 0) begin
                if (r < 7) send(0, r[0], 1'b1, 2);
                else if (r < 18) send(d, 1'b1, 1'b0, 2);
                else send(d, 1'b0, 1'b0, 2);
            end else if (m_loading) begin
                if (r == 0) send(d, 1'b1, 1'b0, 2);
                else if (r == 1) send(d, 1'b0, 1'b1, 2);
                else send(int'($urandom_range(0, 65535)), 1'b0, 1'b0, 2);
            end else begin
                if (r < 3) send(d, 1'b0, 1'b1, 2);
                else if (r < 10) send(d, 1'b1, 1'b0, 2);
                else send(d, 1'b0, 1'b0, 2);
            end
        end

        repeat (3) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
